slice_sum_accumulator: RTL
==========================

SLICE_SUM_ACCUMULATOR -- requirements
Module: slice_sum_accumulator

Interface
REQ-001 Parameter COUNT, default 4, number of accepted input beats summed per output result; legal range 1..16.
REQ-002 Parameter ACC_W, default 8, accumulator and result width in bits; legal range 4..16.
REQ-003 Port clk input 1: single clock; all state updates on the rising edge.
REQ-004 Port rst input 1: reset; synchronous, active-high.
REQ-005 Port in_a input 3: operand A of the current beat.
REQ-006 Port in_b input 3: operand B of the current beat; only bit in_b[1] is used.
REQ-007 Port in_valid input 1: the producer presents a beat on in_a/in_b.
REQ-008 Port in_ready output 1: the block accepts a beat this cycle.
REQ-009 Port out_sum output ACC_W: the completed accumulated result.
REQ-010 Port out_overflow output 1: the result wrapped modulo 2^ACC_W.
REQ-011 Port out_valid output 1: out_sum and out_overflow are valid.
REQ-012 Port out_ready input 1: the consumer takes the result.
REQ-013 Port busy output 1: a partial accumulation or an unconsumed result is held.

Function
REQ-014 Per-beat term SHALL be the 4-bit value in_a + in_b[1] (range 0..8), zero-extended to ACC_W.
REQ-015 An input beat SHALL be accepted exactly in a cycle where in_valid=1 and in_ready=1.
REQ-016 The FSM SHALL have two states: ACCUM, where in_ready=1 and out_valid=0, and HOLD, where in_ready=0 and out_valid=1.
REQ-017 In ACCUM, each accepted beat SHALL set acc <= (acc + term) mod 2^ACC_W and increment beat counter cnt.
REQ-018 In ACCUM, each accepted beat SHALL set the sticky flag ovf if that addition carries out of ACC_W bits.
REQ-019 If the accepted beat is beat number COUNT (cnt==COUNT-1), the block SHALL, on the same edge, load out_sum <= acc+term and out_overflow <= ovf|carry.
REQ-020 On that same edge the block SHALL clear acc, cnt and ovf and enter HOLD.
REQ-021 Latency: out_valid SHALL rise on the cycle immediately after the final beat is accepted.
REQ-022 In HOLD, out_sum and out_overflow SHALL remain stable while out_ready=0, with no timeout.
REQ-023 In HOLD with out_ready=1, the block SHALL return to ACCUM on the next edge; out_valid=0 and in_ready=1 from that cycle.
REQ-024 There SHALL be no same-cycle bypass: a beat offered during the HOLD cycle in which out_ready=1 is not accepted.
REQ-025 Cycles with in_valid=0 in ACCUM SHALL leave acc, cnt and ovf unchanged; gaps are allowed anywhere.
REQ-026 With COUNT=1, every accepted beat SHALL produce a result, giving a maximum throughput of one result per 2 cycles.
REQ-027 busy SHALL equal (state==HOLD) | (cnt!=0).
REQ-028 in_ready SHALL depend only on state (registered) and SHALL NOT depend combinationally on in_valid.

Reset
REQ-029 While rst=1, state SHALL be ACCUM, with acc=0, cnt=0, ovf=0, out_sum=0, out_overflow=0, out_valid=0 and busy=0.
REQ-030 While rst=1, in_ready SHALL be 0 and no beat is accepted.
REQ-031 Reset asserted mid-accumulation or in HOLD SHALL discard the partial sum and any pending result, with no output emitted.

Verification
REQ-032 Nominal case, COUNT=4, ACC_W=8: beats (a,b) = (7,2), (0,0), (5,3), (2,1) give terms 8, 0, 6, 2. Required: out_sum=0x10, out_overflow=0, and out_valid=1 on the cycle after the 4th accept.
REQ-033 Overflow case, COUNT=4, ACC_W=4: four beats (7,2). Required: out_sum=0x0, out_overflow=1. The next group of four beats (1,0) gives out_sum=0x4, out_overflow=0.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in HOLD with in_valid=1. Required: in_ready=0 throughout, out_sum stable, no beat counted. On out_ready=1, out_valid drops next cycle and in_ready=1.
REQ-035 Reset mid-operation, COUNT=4: accept 2 beats (7,2), pulse rst for 1 cycle, then send 4 beats (1,0). Required: single result out_sum=0x04, busy=0 directly after reset.
REQ-036 Gapped input, COUNT=1: random in_valid with random out_ready. Required: every result equals its beat's term, and results and beats match one-to-one in order.

Source files
------------

// File: rtl/slice_sum_accumulator.sv
// slice_sum_accumulator: sums COUNT accepted beats of (in_a + in_b[1]) and holds the result until taken
module slice_sum_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       in_a,
  input  logic [2:0]       in_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  localparam int CW = COUNT > 1 ? $clog2(COUNT) : 1;
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, out_sum_q, out_sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d, out_ovf_q, out_ovf_d;
  logic [3:0]       term;
  logic [ACC_W:0]   sum;
  logic             accept, last;
  logic             unused_b;
  assign unused_b = in_b[2] ^ in_b[0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
    end
  end
  always_comb begin
    term      = {1'b0, in_a} + {3'b0, in_b[1]};
    sum       = {1'b0, acc_q} + (ACC_W + 1)'(term);
    accept    = in_valid & in_ready;
    last      = cnt_q == CW'(COUNT - 1);
    state_d   = state_q == ACCUM ? (accept && last ? HOLD : ACCUM) : (out_ready ? ACCUM : HOLD);
    acc_d     = accept ? (last ? '0 : sum[ACC_W-1:0]) : acc_q;
    cnt_d     = accept ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
    ovf_d     = accept ? (~last & (ovf_q | sum[ACC_W])) : ovf_q;
    out_sum_d = accept && last ? sum[ACC_W-1:0] : out_sum_q;
    out_ovf_d = accept && last ? ovf_q | sum[ACC_W] : out_ovf_q;
  end
  // ready is gated by reset so nothing is offered while rst is held
  always_comb begin
    in_ready     = state_q == ACCUM && !rst;
    out_valid    = state_q == HOLD;
    busy         = state_q == HOLD || cnt_q != '0;
    out_sum      = out_sum_q;
    out_overflow = out_ovf_q;
  end
endmodule
